// File: rtl/tqvp_window_wdt_pkg.sv
// Shared types and constants for the windowed watchdog: channel states,
// register offsets, CTRL field positions and bus write-size handling.
package tqvp_window_wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_BARK = 2'd2,
    ST_BITE = 2'd3
  } wdt_state_e;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_RELOAD = 4'h4;
  localparam logic [3:0] OFF_WINDOW = 4'h8;
  localparam logic [3:0] OFF_TAP    = 4'hC;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_START_BIT = 1;
  localparam int CTRL_LOCK_BIT  = 2;
  localparam int CTRL_STATE_LSB = 4;
  localparam int CTRL_VIOL_BIT  = 6;
  localparam int CTRL_PRE_LSB   = 8;

  localparam logic [31:0] TAP_MAGIC_DEFAULT = 32'h0000_ABCD;

  // 8/16-bit bus writes land zero-extended in the 32-bit register space.
  function automatic logic [31:0] zext_write(input logic [1:0] size_n,
                                             input logic [31:0] dat);
    case (size_n)
      2'b00:   return {24'h0, dat[7:0]};
      2'b01:   return {16'h0, dat[15:0]};
      default: return dat;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_window_wdt_channel.sv
// One watchdog channel: registers, prescaler, down-counter and IDLE/RUN/BARK/BITE FSM.
// Writes act on the presenting edge; read data is combinational, registered by the top.
module tqvp_window_wdt_channel
  import tqvp_window_wdt_pkg::*;
#(
  parameter int          CNT_W     = 24,
  parameter int          PRE_W     = 8,
  parameter logic [31:0] TAP_MAGIC = TAP_MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic [3:0]  off_i,
  input  logic [31:0] wr_dat_i,
  output logic [31:0] rd_dat_o,
  output logic        bark_o,
  output logic        bite_o
);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] window_q, window_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             en_q, en_d;
  logic             lock_q, lock_d;
  logic             viol_q, viol_d;

  logic ctrl_wr, reload_wr, window_wr, tap, active, start, disable_wr;
  logic tick, pre_term, tap_ok, expire;

  assign ctrl_wr    = wr_en_i && (off_i == OFF_CTRL) && !lock_q;
  assign reload_wr  = wr_en_i && (off_i == OFF_RELOAD) && !lock_q;
  assign window_wr  = wr_en_i && (off_i == OFF_WINDOW) && !lock_q;
  assign tap        = wr_en_i && (off_i == OFF_TAP) && (wr_dat_i == TAP_MAGIC);
  assign active     = (state_q == ST_RUN) || (state_q == ST_BARK);
  assign start      = ctrl_wr && wr_dat_i[CTRL_START_BIT] && (reload_q != '0)
                      && (state_q != ST_BITE);
  assign disable_wr = ctrl_wr && !wr_dat_i[CTRL_EN_BIT];
  // A disable written in the same cycle suppresses that cycle's count, so it
  // beats a coincident expiry.
  assign tick       = en_q && active && !disable_wr;
  assign pre_term   = (pre_q >= presc_q);
  assign tap_ok     = (cnt_q <= window_q);
  assign expire     = tick && pre_term && (cnt_q <= CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else if (disable_wr && (state_q == ST_BITE)) begin
      state_d = ST_IDLE;
    end else if (tap && active) begin
      state_d = tap_ok ? ST_RUN : ST_BITE;
    end else if (expire) begin
      state_d = (state_q == ST_RUN) ? ST_BARK : ST_BITE;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    en_d     = en_q;
    lock_d   = lock_q;
    presc_d  = presc_q;
    reload_d = reload_q;
    window_d = window_q;
    viol_d   = viol_q;
    if (ctrl_wr) begin
      en_d    = wr_dat_i[CTRL_EN_BIT];
      lock_d  = lock_q | wr_dat_i[CTRL_LOCK_BIT];
      presc_d = wr_dat_i[CTRL_PRE_LSB +: PRE_W];
    end
    if (reload_wr) reload_d = wr_dat_i[CNT_W-1:0];
    if (window_wr) window_d = wr_dat_i[CNT_W-1:0];
    if (start) begin
      cnt_d = reload_q;
      pre_d = '0;
      en_d  = 1'b1;
    end else if (disable_wr && (state_q == ST_BITE)) begin
      viol_d = 1'b0;
    end else if (tap && active) begin
      // Window check uses the pre-decrement count, so a tap wins over expiry.
      if (tap_ok) begin
        cnt_d = reload_q;
        pre_d = '0;
      end else begin
        viol_d = 1'b1;
      end
    end else if (tick) begin
      if (!pre_term) begin
        pre_d = pre_q + 1'b1;
      end else begin
        pre_d = '0;
        if (!expire)                 cnt_d = cnt_q - 1'b1;
        else if (state_q == ST_RUN)  cnt_d = reload_q;
        else                         cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pre_q    <= '0;
      en_q     <= 1'b0;
      lock_q   <= 1'b0;
      presc_q  <= '0;
      reload_q <= '0;
      window_q <= '0;
      viol_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      en_q     <= en_d;
      lock_q   <= lock_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      window_q <= window_d;
      viol_q   <= viol_d;
    end
  end

  always_comb begin
    bark_o   = (state_q == ST_BARK);
    bite_o   = (state_q == ST_BITE);
    rd_dat_o = '0;
    case (off_i)
      OFF_CTRL: begin
        rd_dat_o[CTRL_EN_BIT]               = en_q;
        rd_dat_o[CTRL_LOCK_BIT]             = lock_q;
        rd_dat_o[CTRL_STATE_LSB +: 2]       = state_q;
        rd_dat_o[CTRL_VIOL_BIT]             = viol_q;
        rd_dat_o[CTRL_PRE_LSB +: PRE_W]     = presc_q;
      end
      OFF_RELOAD: rd_dat_o = 32'(reload_q);
      OFF_WINDOW: rd_dat_o = 32'(window_q);
      OFF_TAP:    rd_dat_o = 32'(cnt_q);
      default:    rd_dat_o = '0;
    endcase
  end

endmodule

// File: rtl/tqvp_window_wdt.sv
// Multi-channel windowed watchdog for the TinyQV peripheral slot.
// Reads return registered data one cycle later with data_ready; writes never stall.
module tqvp_window_wdt
  import tqvp_window_wdt_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 24,
  parameter int          PRE_W     = 8,
  parameter logic [31:0] TAP_MAGIC = TAP_MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  logic             wr_req, rd_req;
  logic [31:0]      wr_dat;
  logic [3:0]       bark, bite;
  logic [3:0][31:0] ch_rd;
  logic [31:0]      data_out_q, data_out_d;
  logic             data_ready_q;
  logic             unused_ui;

  assign unused_ui = ^ui_in;
  assign wr_req    = (data_write_n != 2'b11);
  assign rd_req    = (data_read_n != 2'b11);
  assign wr_dat    = zext_write(data_write_n, data_in);

  for (genvar i = 0; i < 4; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      tqvp_window_wdt_channel #(
        .CNT_W    (CNT_W),
        .PRE_W    (PRE_W),
        .TAP_MAGIC(TAP_MAGIC)
      ) u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en_i (wr_req && (address[5:4] == 2'(i))),
        .off_i   (address[3:0]),
        .wr_dat_i(wr_dat),
        .rd_dat_o(ch_rd[i]),
        .bark_o  (bark[i]),
        .bite_o  (bite[i])
      );
    end else begin : g_off
      assign ch_rd[i] = '0;
      assign bark[i]  = 1'b0;
      assign bite[i]  = 1'b0;
    end
  end

  assign data_out_d = rd_req ? ch_rd[address[5:4]] : data_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_ready_q <= rd_req;
    end
  end

  assign data_out       = data_out_q;
  assign data_ready     = data_ready_q;
  assign uo_out         = {bark, bite};
  assign user_interrupt = |{bark, bite};

endmodule

// File: tb/tb_tqvp_window_wdt.sv
// Directed bench for tqvp_window_wdt with a tick-counting reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_tqvp_window_wdt;

  localparam int     NUM_CH = 2;
  localparam longint MASK   = (64'd1 << 24) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'h00;
  logic [7:0]  uo_out;
  logic [5:0]  address = 6'h00;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  always #5 clk = ~clk;

  tqvp_window_wdt #(
    .NUM_CH(NUM_CH), .CNT_W(24), .PRE_W(8), .TAP_MAGIC(32'h0000ABCD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counter = base - (enabled cycles since load) / (P+1).
  typedef struct {
    int     st;
    bit     en;
    bit     lock;
    bit     viol;
    int     p;
    longint reload;
    longint window;
    longint base;
    longint ticks;
  } mch_t;

  mch_t m [NUM_CH];

  function automatic longint mcnt(input int c);
    return m[c].base - m[c].ticks / (m[c].p + 1);
  endfunction

  function automatic logic [31:0] zx(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return d & 32'h0000_00FF;
    if (sz == 2'b01) return d & 32'h0000_FFFF;
    return d;
  endfunction

  task automatic mstep(input int c);
    bit          wr, old_en, evt;
    logic [31:0] wd;
    int          off;
    longint      cur;
    wr     = (data_write_n != 2'b11) && (int'(address[5:4]) == c);
    wd     = zx(data_write_n, data_in);
    off    = int'(address[3:0]);
    cur    = mcnt(c);
    old_en = m[c].en;
    evt    = 1'b0;
    if (wr && off == 0 && !m[c].lock) begin
      m[c].p    = int'(wd[15:8]);
      m[c].lock = m[c].lock | wd[2];
      if (wd[1] && m[c].reload != 0 && m[c].st != 3) begin
        m[c].base = m[c].reload; m[c].ticks = 0; m[c].en = 1'b1; m[c].st = 1; evt = 1'b1;
      end else begin
        m[c].en = wd[0];
        if (m[c].st == 3 && !wd[0]) begin m[c].st = 0; m[c].viol = 1'b0; end
      end
    end else if (wr && off == 12 && wd == 32'h0000ABCD && (m[c].st == 1 || m[c].st == 2)) begin
      evt = 1'b1;
      if (cur <= m[c].window) begin
        m[c].base = m[c].reload; m[c].ticks = 0; m[c].st = 1;
      end else begin
        m[c].viol = 1'b1; m[c].st = 3; m[c].base = cur; m[c].ticks = 0;
      end
    end else if (wr && off == 4 && !m[c].lock) begin
      m[c].reload = longint'(wd) & MASK;
    end else if (wr && off == 8 && !m[c].lock) begin
      m[c].window = longint'(wd) & MASK;
    end
    if (!evt && (m[c].st == 1 || m[c].st == 2) && old_en && m[c].en) begin
      m[c].ticks++;
      if (m[c].ticks == m[c].base * (m[c].p + 1)) begin
        if (m[c].st == 1) begin m[c].st = 2; m[c].base = m[c].reload; end
        else begin m[c].st = 3; m[c].base = 0; end
        m[c].ticks = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) m[c] = '{0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    end else begin
      for (int c = 0; c < NUM_CH; c++) mstep(c);
    end
  end

  function automatic logic [31:0] mread(input logic [5:0] a);
    int          c;
    logic [31:0] r;
    c = int'(a[5:4]);
    r = '0;
    if (c < NUM_CH) begin
      case (a[3:0])
        4'h0: begin
          r[0] = m[c].en; r[2] = m[c].lock; r[5:4] = 2'(m[c].st);
          r[6] = m[c].viol; r[15:8] = 8'(m[c].p);
        end
        4'h4: r = 32'(m[c].reload);
        4'h8: r = 32'(m[c].window);
        4'hC: r = 32'(mcnt(c));
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  logic [7:0] exp_uo;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_uo = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        exp_uo[c]     = (m[c].st == 3);
        exp_uo[4 + c] = (m[c].st == 2);
      end
      check("cyc_uo_out", 32'(uo_out), 32'(exp_uo));
      check("cyc_irq", 32'(user_interrupt), 32'(|exp_uo));
    end
  end

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    address = a; data_in = d; data_write_n = sz;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input string name, input logic [5:0] a, input logic [31:0] lit);
    logic [31:0] mexp;
    address = a; data_read_n = 2'b10; mexp = mread(a);
    @(posedge clk); #1;
    data_read_n = 2'b11;
    check({name, "_rdy"}, 32'(data_ready), 32'd1);
    check({name, "_lit"}, data_out, lit);
    check({name, "_mdl"}, data_out, mexp);
  endtask

  task automatic chk_uo(input string name, input logic [7:0] e);
    check(name, 32'(uo_out), 32'(e));
    check({name, "_irq"}, 32'(user_interrupt), 32'(e != 8'h00));
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    chk_uo("rst_uo", 8'h00);
    check("rst_dout", data_out, 32'h0);
    check("rst_rdy", 32'(data_ready), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Ch0 RELOAD=10, P=0: bark 10 cycles after start, bite 10 later.
    wr(6'h04, 32'd10, 2'b10);
    wr(6'h00, 32'h3, 2'b10);
    idle(9);  chk_uo("t1_pre_bark", 8'h00);
    idle(1);  chk_uo("t1_bark", 8'h10);
    idle(9);  chk_uo("t1_pre_bite", 8'h10);
    idle(1);  chk_uo("t1_bite", 8'h01);
    wr(6'h00, 32'h0, 2'b10);
    chk_uo("t1_idle", 8'h00);

    // Window: early tap bites, in-window tap reloads.
    wr(6'h04, 32'd100, 2'b10);
    wr(6'h08, 32'd20, 2'b10);
    wr(6'h00, 32'h3, 2'b10);
    idle(50);
    wr(6'h0C, 32'h0000ABCD, 2'b10);
    rd("t2_viol_ctrl", 6'h00, 32'h0000_0071);
    wr(6'h00, 32'h0, 2'b10);
    rd("t2_clr_ctrl", 6'h00, 32'h0);
    wr(6'h00, 32'h3, 2'b10);
    idle(85);
    wr(6'h0C, 32'h0000ABCD, 2'b10);
    rd("t2_tap_cnt", 6'h0C, 32'd100);
    rd("t2_run_ctrl", 6'h00, 32'h0000_0011);

    // P=3, RELOAD=4: bark after 16 cycles; disable freezes the count.
    wr(6'h04, 32'd4, 2'b10);
    wr(6'h00, 32'h0303, 2'b01);
    idle(15); chk_uo("t3_pre_bark", 8'h00);
    idle(1);  chk_uo("t3_bark", 8'h10);
    wr(6'h00, 32'h0303, 2'b01);
    idle(5);
    wr(6'h00, 32'h0300, 2'b01);
    idle(20);
    rd("t3_frozen_cnt", 6'h0C, 32'd3);
    rd("t3_frozen_ctrl", 6'h00, 32'h0000_0310);
    wr(6'h00, 32'h0301, 2'b01);
    idle(30); chk_uo("t3_bite", 8'h01);
    wr(6'h00, 32'h0, 2'b10);

    // Lock on ch1: RELOAD and CTRL writes ignored, taps still honoured.
    wr(6'h14, 32'd30, 2'b10);
    wr(6'h18, 32'd30, 2'b10);
    wr(6'h10, 32'h7, 2'b10);
    wr(6'h14, 32'd5, 2'b10);
    wr(6'h10, 32'h0, 2'b10);
    rd("t4_lock_ctrl", 6'h10, 32'h0000_0015);
    rd("t4_lock_reload", 6'h14, 32'd30);
    wr(6'h1C, 32'h0000ABCD, 2'b10);
    rd("t4_lock_tap", 6'h1C, 32'd30);
    rst_n = 1'b0;
    #1;
    check("t4_arst_rdy", 32'(data_ready), 32'h0);
    check("t4_arst_dout", data_out, 32'h0);
    chk_uo("t4_arst_uo", 8'h00);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    rd("t4_post_rst_ctrl", 6'h10, 32'h0);
    wr(6'h18, 32'd7, 2'b10);
    rd("t4_unlocked_win", 6'h18, 32'd7);

    // Wrong tap value ignored; 16-bit magic tap accepted; IDLE tap and zero-reload start ignored.
    wr(6'h08, 32'd20, 2'b10);
    wr(6'h04, 32'hFFFF_FF14, 2'b00);
    rd("t5_reload8", 6'h04, 32'd20);
    wr(6'h00, 32'h3, 2'b10);
    idle(5);
    wr(6'h0C, 32'h0000_1234, 2'b10);
    rd("t5_badtap_cnt", 6'h0C, 32'd14);
    wr(6'h0C, 32'hFFFF_ABCD, 2'b01);
    rd("t5_tap16_cnt", 6'h0C, 32'd20);
    wr(6'h1C, 32'h0000ABCD, 2'b10);
    rd("t5_idle_tap", 6'h10, 32'h0);
    wr(6'h10, 32'h2, 2'b10);
    rd("t5_zero_start", 6'h10, 32'h0);
    wr(6'h00, 32'h0, 2'b10);

    // Two channels with different reloads: independent pins, ORed interrupt.
    wr(6'h04, 32'd6, 2'b10);
    wr(6'h14, 32'd9, 2'b10);
    wr(6'h00, 32'h3, 2'b10);
    wr(6'h10, 32'h3, 2'b10);
    idle(5);  chk_uo("t6_ch0_bark", 8'h10);
    idle(4);  chk_uo("t6_both_bark", 8'h30);
    idle(2);  chk_uo("t6_bite0_bark1", 8'h21);
    idle(7);  chk_uo("t6_both_bite", 8'h03);
    rd("t6_ch3_read", 6'h30, 32'h0);
    idle(1);
    check("t6_rdy_drop", 32'(data_ready), 32'h0);
    rd("t6_undef_off", 6'h02, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
